// File: rtl/hack_pkg.sv
// Shared HACK-platform types and widths.
// Used by the instruction-memory loader and its RAM.
package hack_pkg;

    localparam int unsigned HACK_WORD_W = 16;
    localparam int unsigned HACK_ADDR_W = 15;

    typedef enum logic [2:0] {
        S_LEN_H,
        S_LEN_L,
        S_DAT_H,
        S_DAT_L,
        S_SUM_H,
        S_SUM_L,
        S_RUN,
        S_ERR
    } imem_ld_state_t;

endpackage

// File: rtl/hack_imem_ram.sv
// Instruction store: one synchronous write port, one asynchronous read port.
// Contents are never cleared.
module hack_imem_ram
    import hack_pkg::*;
#(
    parameter int unsigned DEPTH_LOG2 = 12
) (
    input  logic                   clk_i,
    input  logic                   we_i,
    input  logic [DEPTH_LOG2-1:0]  waddr_i,
    input  logic [HACK_WORD_W-1:0] wdata_i,
    input  logic [DEPTH_LOG2-1:0]  raddr_i,
    output logic [HACK_WORD_W-1:0] rdata_o
);

    logic [HACK_WORD_W-1:0] mem_q [0:(2**DEPTH_LOG2)-1];

    always_ff @(posedge clk_i) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/hack_imem_loader.sv
// HACK instruction memory with a checksummed byte-stream loader.
// Holds the CPU in reset until a complete image with a matching checksum is present.
module hack_imem_loader
    import hack_pkg::*;
#(
    parameter int unsigned DEPTH_LOG2 = 12
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic [HACK_ADDR_W-1:0] pc,
    output logic [HACK_WORD_W-1:0] instr,
    input  logic                   ld_valid,
    input  logic [7:0]             ld_data,
    output logic                   ld_ready,
    input  logic                   reload,
    output logic                   cpu_reset,
    output logic                   error,
    output logic [15:0]            words_loaded
);

    localparam logic [16:0] MaxWords = 17'(2**DEPTH_LOG2);

    imem_ld_state_t state_q, state_d;
    logic [7:0]              len_hi_q, len_hi_d;
    logic [15:0]             len_q, len_d;
    logic [7:0]              hi_q, hi_d;
    logic [7:0]              sum_hi_q, sum_hi_d;
    logic [15:0]             sum_q, sum_d;
    logic [DEPTH_LOG2-1:0]   addr_q, addr_d;
    logic [15:0]             words_q, words_d;

    logic                    accept;
    logic                    we;
    logic [HACK_WORD_W-1:0]  wdata;
    logic [HACK_WORD_W-1:0]  rdata;
    logic [15:0]             len_n;
    logic [15:0]             words_inc;

    assign ld_ready  = (state_q != S_RUN) && (state_q != S_ERR);
    assign accept    = ld_valid & ld_ready;
    assign wdata     = {hi_q, ld_data};
    assign len_n     = {len_hi_q, ld_data};
    assign words_inc = words_q + 16'd1;

    always_comb begin
        state_d  = state_q;
        len_hi_d = len_hi_q;
        len_d    = len_q;
        hi_d     = hi_q;
        sum_hi_d = sum_hi_q;
        sum_d    = sum_q;
        addr_d   = addr_q;
        words_d  = words_q;
        we       = 1'b0;
        unique case (state_q)
            S_LEN_H: begin
                if (accept) begin
                    len_hi_d = ld_data;
                    state_d  = S_LEN_L;
                end
            end
            S_LEN_L: begin
                if (accept) begin
                    if (len_n == 16'd0 || {1'b0, len_n} > MaxWords) begin
                        state_d = S_ERR;
                    end else begin
                        len_d   = len_n;
                        addr_d  = '0;
                        sum_d   = '0;
                        words_d = '0;
                        state_d = S_DAT_H;
                    end
                end
            end
            S_DAT_H: begin
                if (accept) begin
                    hi_d    = ld_data;
                    state_d = S_DAT_L;
                end
            end
            S_DAT_L: begin
                if (accept) begin
                    we      = 1'b1;
                    addr_d  = addr_q + DEPTH_LOG2'(1);
                    words_d = words_inc;
                    sum_d   = sum_q + wdata;
                    // Leaving at N is what makes words_loaded saturate.
                    state_d = (words_inc == len_q) ? S_SUM_H : S_DAT_H;
                end
            end
            S_SUM_H: begin
                if (accept) begin
                    sum_hi_d = ld_data;
                    state_d  = S_SUM_L;
                end
            end
            S_SUM_L: begin
                if (accept) begin
                    state_d = ({sum_hi_q, ld_data} == sum_q) ? S_RUN : S_ERR;
                end
            end
            S_RUN: begin
                if (reload) begin
                    words_d = '0;
                    state_d = S_LEN_H;
                end
            end
            S_ERR: begin
                state_d = S_ERR;
            end
            default: begin
                state_d = S_ERR;
            end
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q  <= S_LEN_H;
            len_hi_q <= '0;
            len_q    <= '0;
            hi_q     <= '0;
            sum_hi_q <= '0;
            sum_q    <= '0;
            addr_q   <= '0;
            words_q  <= '0;
        end else begin
            state_q  <= state_d;
            len_hi_q <= len_hi_d;
            len_q    <= len_d;
            hi_q     <= hi_d;
            sum_hi_q <= sum_hi_d;
            sum_q    <= sum_d;
            addr_q   <= addr_d;
            words_q  <= words_d;
        end
    end

    hack_imem_ram #(
        .DEPTH_LOG2(DEPTH_LOG2)
    ) u_ram (
        .clk_i  (clock),
        .we_i   (we),
        .waddr_i(addr_q),
        .wdata_i(wdata),
        .raddr_i(pc[DEPTH_LOG2-1:0]),
        .rdata_o(rdata)
    );

    assign instr        = ((pc >> DEPTH_LOG2) == '0) ? rdata : '0;
    assign cpu_reset    = (state_q != S_RUN);
    assign error        = (state_q == S_ERR);
    assign words_loaded = words_q;

endmodule

// File: tb/tb_hack_imem_loader.sv
// Bench for hack_imem_loader: frame table, corner-case sequences and
// random frames checked against a word-level model of the load protocol.
module tb_hack_imem_loader;

    localparam int unsigned D     = 12;
    localparam int          Depth = 1 << D;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic [14:0] pc = '0;
    logic [15:0] instr;
    logic        ld_valid = 1'b0;
    logic [7:0]  ld_data = '0;
    logic        ld_ready;
    logic        reload = 1'b0;
    logic        cpu_reset;
    logic        error;
    logic [15:0] words_loaded;

    int errors = 0;
    int checks = 0;

    logic [7:0] frame_q[$];

    typedef struct packed {
        logic [95:0] bytes;      // first byte in the top byte lane
        logic [7:0]  nbytes;
        logic        exp_err;
        logic [15:0] exp_words;
        logic [14:0] probe_pc;
        logic [15:0] probe_instr;
    } vec_t;

    localparam int NV = 6;
    vec_t vecs [NV];

    hack_imem_loader #(
        .DEPTH_LOG2(D)
    ) dut (
        .clock       (clock),
        .reset       (reset),
        .pc          (pc),
        .instr       (instr),
        .ld_valid    (ld_valid),
        .ld_data     (ld_data),
        .ld_ready    (ld_ready),
        .reload      (reload),
        .cpu_reset   (cpu_reset),
        .error       (error),
        .words_loaded(words_loaded)
    );

    always #5 clock = ~clock;

    initial begin
        #3000000;
        $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic do_reset();
        reset    = 1'b1;
        ld_valid = 1'b0;
        reload   = 1'b0;
        step();
        step();
        reset = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] b, input int gap);
        int n;
        ld_valid = 1'b0;
        repeat (gap) step();
        ld_valid = 1'b1;
        ld_data  = b;
        n = 0;
        while (!ld_ready && n < 8) begin
            step();
            n++;
        end
        if (!ld_ready) begin
            check("ld_ready timeout", {31'd0, ld_ready}, 32'd1);
            ld_valid = 1'b0;
            return;
        end
        step();
        ld_valid = 1'b0;
    endtask

    task automatic send_frame(input int max_gap);
        foreach (frame_q[i]) send_byte(frame_q[i], $urandom_range(0, max_gap));
    endtask

    task automatic probe(input string name, input logic [14:0] p, input logic [15:0] exp);
        pc = p;
        @(negedge clock);
        check(name, {16'd0, instr}, {16'd0, exp});
    endtask

    task automatic pulse_reload();
        reload = 1'b1;
        step();
        reload = 1'b0;
    endtask

    // Word-level model: build a frame from word values, optionally corrupt its checksum.
    task automatic build_frame(input logic [15:0] w[$], input bit good);
        int s;
        logic [15:0] sum16;
        s = 0;
        foreach (w[i]) s = (s + int'(w[i])) % 65536;
        sum16 = 16'(s);
        if (!good) sum16 = sum16 ^ 16'(1 + $urandom_range(0, 65534));
        frame_q.delete();
        frame_q.push_back(8'(w.size() >> 8));
        frame_q.push_back(8'(w.size()));
        foreach (w[i]) begin
            frame_q.push_back(w[i][15:8]);
            frame_q.push_back(w[i][7:0]);
        end
        frame_q.push_back(sum16[15:8]);
        frame_q.push_back(sum16[7:0]);
    endtask

    initial begin
        vecs[0] = '{bytes: 96'h0003_0005_EC10_0000_EC15_0000, nbytes: 8'd10, exp_err: 1'b0,
                    exp_words: 16'd3, probe_pc: 15'd1, probe_instr: 16'hEC10};
        vecs[1] = '{bytes: 96'h0003_0005_EC10_0000_0000_0000, nbytes: 8'd10, exp_err: 1'b1,
                    exp_words: 16'd3, probe_pc: 15'd0, probe_instr: 16'h0005};
        vecs[2] = '{bytes: 96'h0000_0000_0000_0000_0000_0000, nbytes: 8'd2, exp_err: 1'b1,
                    exp_words: 16'd0, probe_pc: 15'h7FFF, probe_instr: 16'h0000};
        vecs[3] = '{bytes: 96'h1001_0000_0000_0000_0000_0000, nbytes: 8'd2, exp_err: 1'b1,
                    exp_words: 16'd0, probe_pc: 15'h4000, probe_instr: 16'h0000};
        vecs[4] = '{bytes: 96'h0001_ABCD_ABCD_0000_0000_0000, nbytes: 8'd6, exp_err: 1'b0,
                    exp_words: 16'd1, probe_pc: 15'd0, probe_instr: 16'hABCD};
        vecs[5] = '{bytes: 96'h0002_FFFF_0002_0001_0000_0000, nbytes: 8'd8, exp_err: 1'b0,
                    exp_words: 16'd2, probe_pc: 15'd1, probe_instr: 16'h0002};

        // Reset state
        do_reset();
        repeat (3) step();
        check("rst cpu_reset", {31'd0, cpu_reset}, 32'd1);
        check("rst ld_ready", {31'd0, ld_ready}, 32'd1);
        check("rst error", {31'd0, error}, 32'd0);
        check("rst words", {16'd0, words_loaded}, 32'd0);

        // Table of whole frames, random gaps between bytes
        for (int t = 0; t < NV; t++) begin
            do_reset();
            frame_q.delete();
            for (int i = 0; i < int'(vecs[t].nbytes); i++) frame_q.push_back(vecs[t].bytes[95-8*i -: 8]);
            send_frame(3);
            check($sformatf("v%0d error", t), {31'd0, error}, {31'd0, vecs[t].exp_err});
            check($sformatf("v%0d cpu_reset", t), {31'd0, cpu_reset}, {31'd0, vecs[t].exp_err});
            check($sformatf("v%0d ld_ready", t), {31'd0, ld_ready}, 32'd0);
            check($sformatf("v%0d words", t), {16'd0, words_loaded}, {16'd0, vecs[t].exp_words});
            probe($sformatf("v%0d instr", t), vecs[t].probe_pc, vecs[t].probe_instr);
        end

        // cpu_reset falls exactly on the SUM_L edge; out-of-range pc reads zero
        do_reset();
        frame_q = '{8'h00, 8'h03, 8'h00, 8'h05, 8'hEC, 8'h10, 8'h00, 8'h00, 8'hEC};
        send_frame(0);
        check("pre-sum cpu_reset", {31'd0, cpu_reset}, 32'd1);
        send_byte(8'h15, 0);
        check("sum edge cpu_reset", {31'd0, cpu_reset}, 32'd0);
        probe("pc0", 15'd0, 16'h0005);
        probe("pc1", 15'd1, 16'hEC10);
        probe("pc2", 15'd2, 16'h0000);
        probe("pc 0x4000", 15'h4000, 16'h0000);

        // Bad checksum: sticky error, ld_valid and reload ignored
        do_reset();
        frame_q = '{8'h00, 8'h03, 8'h00, 8'h05, 8'hEC, 8'h10, 8'h00, 8'h00, 8'h00, 8'h00};
        send_frame(1);
        ld_valid = 1'b1;
        ld_data  = 8'h55;
        repeat (4) step();
        pulse_reload();
        ld_valid = 1'b0;
        step();
        check("err sticky", {31'd0, error}, 32'd1);
        check("err cpu_reset", {31'd0, cpu_reset}, 32'd1);
        check("err ld_ready", {31'd0, ld_ready}, 32'd0);
        check("err words", {16'd0, words_loaded}, 32'd3);
        do_reset();
        check("err cleared", {31'd0, error}, 32'd0);

        // Reset mid-frame after 5 bytes, reload ignored while loading
        frame_q = '{8'h00, 8'h03, 8'h00, 8'h05, 8'hEC};
        send_frame(2);
        check("mid words", {16'd0, words_loaded}, 32'd1);
        pulse_reload();
        check("mid reload ignored", {16'd0, words_loaded}, 32'd1);
        check("mid cpu_reset", {31'd0, cpu_reset}, 32'd1);
        do_reset();
        check("mid rst words", {16'd0, words_loaded}, 32'd0);
        frame_q = '{8'h00, 8'h01, 8'h12, 8'h34, 8'h12, 8'h34};
        send_frame(2);
        check("restart cpu_reset", {31'd0, cpu_reset}, 32'd0);
        probe("restart pc0", 15'd0, 16'h1234);

        // Reload from RUN
        pulse_reload();
        check("reload cpu_reset", {31'd0, cpu_reset}, 32'd1);
        check("reload ld_ready", {31'd0, ld_ready}, 32'd1);
        check("reload words", {16'd0, words_loaded}, 32'd0);
        frame_q = '{8'h00, 8'h01, 8'hAB, 8'hCD, 8'hAB, 8'hCD};
        send_frame(1);
        check("reload run", {31'd0, cpu_reset}, 32'd0);
        probe("reload pc0", 15'd0, 16'hABCD);

        // Random frames against the word-level model
        for (int f = 0; f < 12; f++) begin
            logic [15:0] w[$];
            int n;
            bit good;
            n = (f == 5) ? Depth : $urandom_range(1, 40);
            good = ($urandom_range(0, 3) != 0);
            w.delete();
            for (int i = 0; i < n; i++) w.push_back(16'($urandom));
            build_frame(w, good);
            if (!cpu_reset) pulse_reload();
            else do_reset();
            send_frame((n > 100) ? 1 : 3);
            check($sformatf("r%0d error", f), {31'd0, error}, {31'd0, !good});
            check($sformatf("r%0d cpu_reset", f), {31'd0, cpu_reset}, {31'd0, !good});
            check($sformatf("r%0d words", f), {16'd0, words_loaded}, n);
            for (int k = 0; k < 4; k++) begin
                int a;
                a = (k == 0) ? n - 1 : $urandom_range(0, n - 1);
                probe($sformatf("r%0d instr[%0d]", f, a), 15'(a), w[a]);
            end
            probe($sformatf("r%0d oob", f), 15'($urandom_range(Depth, 32767)), 16'h0000);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
